// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and state type for the display scan controller
package disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {IDLE, GUARD, DRIVE} scan_state_t;

  // All-ones anode pattern; the caller size-casts it to the digit count.
  function automatic logic [31:0] AN_OFF(input int unsigned width);
    return ~(32'hFFFF_FFFF << width);
  endfunction

endpackage

// File: rtl/driverDisplay7Segements.sv
// rtl/driverDisplay7Segements.sv - BCD to active-low seven-segment decoder {g,f,e,d,c,b,a}
module driverDisplay7Segements
  import disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - multiplexed seven-segment scan with guard gap and frame-aligned value commit
module display_scan_controller
  import disp_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int SLOT_CYCLES   = 50000,
  parameter int GUARD_CYCLES  = 500,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  output logic                  ready,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an
);

  localparam int MAX_CYC = (SLOT_CYCLES > GUARD_CYCLES) ? SLOT_CYCLES : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam bit HAS_GUARD = (GUARD_CYCLES > 0);

  localparam logic [CNT_W-1:0]    SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0]    GUARD_LAST = CNT_W'(HAS_GUARD ? GUARD_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_ALL     = N_DIGITS'(AN_OFF(N_DIGITS));

  scan_state_t           state;
  logic [4*N_DIGITS-1:0] disp_reg;
  logic [4*N_DIGITS-1:0] pend_reg;
  logic                  pend_valid;
  logic [IDX_W-1:0]      digit_idx;
  logic [CNT_W-1:0]      cnt;

  logic [IDX_W-1:0]      nxt_idx;
  logic                  slot_end;
  logic                  commit_now;
  logic [IDX_W-1:0]      dec_idx;
  logic [4*N_DIGITS-1:0] dec_val;
  logic [3:0]            nib;
  logic                  upper_nz;
  logic [3:0]            dec_bcd;
  logic [6:0]            dec_seg;
  logic [N_DIGITS-1:0]   drive_an;

  assign ready = ~pend_valid;

  // The decoder looks at the digit about to be driven so an and seg update on the same edge.
  always_comb begin
    nxt_idx    = (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
    slot_end   = (state == DRIVE) && (cnt == SLOT_LAST);
    commit_now = slot_end && (nxt_idx == '0) && pend_valid;

    case (state)
      IDLE:    dec_idx = '0;
      GUARD:   dec_idx = digit_idx;
      default: dec_idx = nxt_idx;
    endcase

    if (state == IDLE && load)
      dec_val = value;
    else if (commit_now)
      dec_val = pend_reg;
    else
      dec_val = disp_reg;

    nib      = BCD_BLANK;
    upper_nz = 1'b0;
    drive_an = AN_ALL;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (IDX_W'(i) == dec_idx) begin
        nib         = dec_val[4*i +: 4];
        drive_an[i] = 1'b0;
      end
      if (IDX_W'(i) >= dec_idx && dec_val[4*i +: 4] != 4'd0)
        upper_nz = 1'b1;
    end

    dec_bcd = (BLANK_LEADING != 0 && dec_idx != '0 && !upper_nz) ? BCD_BLANK : nib;
  end

  driverDisplay7Segements u_dec (
    .bcd (dec_bcd),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      digit_idx  <= '0;
      cnt        <= '0;
      disp_reg   <= '0;
      pend_reg   <= '0;
      pend_valid <= 1'b0;
      an         <= AN_ALL;
      seg        <= SEG_BLANK;
    end else if (!enable) begin
      // A load in the same cycle as disable lands straight in disp_reg via the IDLE-entry commit.
      state     <= IDLE;
      digit_idx <= '0;
      cnt       <= '0;
      an        <= AN_ALL;
      seg       <= SEG_BLANK;
      if (load && ready)
        disp_reg <= value;
      else if (pend_valid)
        disp_reg <= pend_reg;
      pend_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load)
            disp_reg <= value;
          digit_idx <= '0;
          cnt       <= '0;
          if (HAS_GUARD) begin
            state <= GUARD;
            an    <= AN_ALL;
            seg   <= SEG_BLANK;
          end else begin
            state <= DRIVE;
            an    <= drive_an;
            seg   <= dec_seg;
          end
        end

        GUARD: begin
          if (load && ready) begin
            pend_reg   <= value;
            pend_valid <= 1'b1;
          end
          if (cnt == GUARD_LAST) begin
            state <= DRIVE;
            cnt   <= '0;
            an    <= drive_an;
            seg   <= dec_seg;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DRIVE: begin
          if (load && ready) begin
            pend_reg   <= value;
            pend_valid <= 1'b1;
          end
          if (slot_end) begin
            cnt       <= '0;
            digit_idx <= nxt_idx;
            if (commit_now) begin
              disp_reg   <= pend_reg;
              pend_valid <= 1'b0;
            end
            if (HAS_GUARD) begin
              state <= GUARD;
              an    <= AN_ALL;
              seg   <= SEG_BLANK;
            end else begin
              an  <= drive_an;
              seg <= dec_seg;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          an    <= AN_ALL;
          seg   <= SEG_BLANK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - directed self-checking bench for display_scan_controller
module tb_display_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic        ready;
  logic [6:0]  seg;
  logic [3:0]  an;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SB = 7'h7F;

  display_scan_controller #(
    .N_DIGITS(4), .SLOT_CYCLES(4), .GUARD_CYCLES(1), .BLANK_LEADING(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value),
    .ready(ready), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // exp packs {digit3, digit2, digit1, digit0} segment patterns; frame position 0 is the guard before digit 0.
  task automatic run_and_check(input logic [27:0] exp, input int ncyc, input int start_pos, input string name);
    int pos;
    int slot;
    logic [3:0] ean;
    logic [6:0] eseg;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      pos  = (start_pos + i) % 20;
      slot = pos / 5;
      ean  = 4'b1111;
      if (pos % 5 == 0) begin
        eseg = 7'h7F;
      end else begin
        ean[slot] = 1'b0;
        eseg      = exp[7*slot +: 7];
      end
      total++;
      if (an !== ean || seg !== eseg) begin
        bad++;
        $display("FAIL %s pos=%0d: got an=%b seg=%b, want an=%b seg=%b", name, pos, an, seg, ean, eseg);
      end
    end
  endtask

  task automatic check_ready(input logic exp, input string name);
    total++;
    if (ready !== exp) begin
      bad++;
      $display("FAIL %s: got ready=%b, want %b", name, ready, exp);
    end
  endtask

  task automatic check_dark(input string name);
    total++;
    if (an !== 4'b1111 || seg !== 7'h7F || ready !== 1'b1) begin
      bad++;
      $display("FAIL %s: got an=%b seg=%h ready=%b, want an=1111 seg=7f ready=1", name, an, seg, ready);
    end
  endtask

  task automatic load_idle(input logic [15:0] v);
    enable = 1'b0;
    @(posedge clk); #1;
    value = v; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check_ready(1'b1, "idle_load_ready");
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; load = 1'b0; value = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_dark("reset_values");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_dark("idle_dark");
    end
  endtask

  task automatic test_scan_1234();
    load_idle(16'h1234);
    enable = 1'b1;
    run_and_check({S1, S2, S3, S4}, 40, 0, "scan_1234");
  endtask

  task automatic test_leading_blank();
    load_idle(16'h0070);
    enable = 1'b1;
    run_and_check({SB, SB, S7, S0}, 20, 0, "blank_0070");
    load_idle(16'h0000);
    enable = 1'b1;
    run_and_check({SB, SB, SB, S0}, 20, 0, "blank_0000");
  endtask

  task automatic test_pending_commit();
    load_idle(16'h1234);
    enable = 1'b1;
    run_and_check({S1, S2, S3, S4}, 12, 0, "pend_before");
    check_ready(1'b1, "pend_ready_before");
    value = 16'h5678; load = 1'b1;
    run_and_check({S1, S2, S3, S4}, 1, 12, "pend_accept");
    load = 1'b0;
    check_ready(1'b0, "pend_ready_low");
    run_and_check({S1, S2, S3, S4}, 7, 13, "pend_old_frame");
    check_ready(1'b0, "pend_ready_held");
    run_and_check({S5, S6, S7, S8}, 1, 0, "commit_guard");
    check_ready(1'b1, "commit_ready");
    run_and_check({S5, S6, S7, S8}, 19, 1, "new_frame");
  endtask

  task automatic test_disable_mid_drive();
    run_and_check({S5, S6, S7, S8}, 3, 0, "pre_disable");
    enable = 1'b0;
    @(posedge clk); #1;
    check_dark("disable_dark");
    @(posedge clk); #1;
    check_dark("disable_hold");
    enable = 1'b1;
    run_and_check({S5, S6, S7, S8}, 6, 0, "reenable");
  endtask

  task automatic test_nibble_b();
    load_idle(16'h12B4);
    enable = 1'b1;
    run_and_check({S1, S2, SB, S4}, 20, 0, "nibble_b");
  endtask

  task automatic test_rst_mid_frame();
    run_and_check({S1, S2, SB, S4}, 8, 0, "pre_rst");
    value = 16'h9999; load = 1'b1;
    run_and_check({S1, S2, SB, S4}, 1, 8, "pre_rst_load");
    load = 1'b0;
    check_ready(1'b0, "pre_rst_ready");
    rst = 1'b1;
    @(posedge clk); #1;
    check_dark("rst_mid_frame");
    rst = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    check_dark("post_rst_idle");
    enable = 1'b1;
    run_and_check({SB, SB, SB, S0}, 20, 0, "post_rst_cleared");
  endtask

  initial begin
    test_reset();
    test_scan_1234();
    test_leading_blank();
    test_pending_commit();
    test_disable_mid_drive();
    test_nibble_b();
    test_rst_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
